// File: rtl/btn_event_arb.sv
// Button event arbiter: turns press and long-press events into ASCII bytes for a
// UART transmitter, serving a vector of pending flags round-robin.

module btn_event_arb #(
    parameter int NBTN     = 4,
    parameter     LONG_CNT = 26'h2FA_F080,
    parameter int CW       = 26
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NBTN-1:0]   btn,
    input  logic              tx_ready,
    input  logic              clr_ovf,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic [2*NBTN-1:0] pending,
    output logic              ovf
);

    localparam int NB = 2 * NBTN;
    localparam int PW = $clog2(NB);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CNT);
    localparam logic [CW-1:0] LONG_M1  = CW'(LONG_CNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nx;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   gidx_nx;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   scan;
    logic            found;
    logic [NBTN-1:0] btn_q;
    logic [NBTN-1:0] press_ev;
    logic [NBTN-1:0] long_ev;
    logic [CW-1:0]   cnt [NBTN];
    logic [NB-1:0]   event_vec;
    logic [NB-1:0]   grant_vec;
    logic [NB-1:0]   pending_nx;
    logic            lost;
    logic            tx_valid_nx;
    logic [7:0]      tx_data_nx;
    logic            ovf_nx;

    function automatic logic [7:0] event_code(input logic [PW-1:0] idx);
        if (idx < PW'(NBTN)) begin
            return 8'h41 + 8'(idx);
        end
        return 8'h61 + 8'(idx) - 8'(NBTN);
    endfunction

    assign press_ev = btn & ~btn_q;

    // The long event fires only on the single step into saturation.
    always_comb begin
        long_ev = '0;
        for (int i = 0; i < NBTN; i++) begin
            long_ev[i] = btn[i] & (cnt[i] == LONG_M1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (!btn[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != LONG_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // First set pending bit at or above ptr, wrapping around the vector.
    always_comb begin
        sel   = ptr;
        scan  = ptr;
        found = 1'b0;
        for (int k = 0; k < NB; k++) begin
            scan = PW'((int'(ptr) + k) % NB);
            if (!found && pending[scan]) begin
                sel   = scan;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        gidx_nx     = gidx;
        tx_valid_nx = tx_valid;
        tx_data_nx  = tx_data;
        grant_vec   = '0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    grant_vec[sel] = 1'b1;
                    gidx_nx        = sel;
                    tx_valid_nx    = 1'b1;
                    tx_data_nx     = event_code(sel);
                    state_nx       = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_valid_nx = 1'b0;
                    ptr_nx      = (gidx == PW'(NB - 1)) ? '0 : gidx + 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A new event on a flag being granted re-arms it without counting as lost.
        event_vec  = {long_ev, press_ev};
        lost       = |(event_vec & pending & ~grant_vec);
        pending_nx = (pending & ~grant_vec) | event_vec;
        ovf_nx     = lost | (ovf & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gidx     <= '0;
            btn_q    <= '0;
            pending  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            gidx     <= gidx_nx;
            btn_q    <= btn;
            pending  <= pending_nx;
            tx_valid <= tx_valid_nx;
            tx_data  <= tx_data_nx;
            ovf      <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_btn_event_arb.sv
// Bench for btn_event_arb: directed scenarios with literal expectations, then
// randomized buttons/handshake checked every cycle against a behavioural model.

module tb_btn_event_arb;

    localparam int NBTN = 4;
    localparam int NB   = 2 * NBTN;
    localparam int LONG = 10;
    localparam int CW   = 26;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic [NBTN-1:0] btn = '0;
    logic            tx_ready = 1'b0;
    logic            clr_ovf = 1'b0;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic [NB-1:0]   pending;
    logic            ovf;

    int checks = 0;
    int failures = 0;

    // Model state: consecutive-high sample counts, flag set, byte in flight.
    int         hold [NBTN];
    bit         mpend [NB];
    bit         movf;
    bit         mvalid;
    int         mptr;
    int         mgidx;
    logic [7:0] mdata;

    always #5 clk = ~clk;

    btn_event_arb #(
        .NBTN(NBTN),
        .LONG_CNT(LONG),
        .CW(CW)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .btn(btn),
        .tx_ready(tx_ready),
        .clr_ovf(clr_ovf),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .pending(pending),
        .ovf(ovf)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NBTN-1:0] b, input logic rdy, input logic clr);
        btn      = b;
        tx_ready = rdy;
        clr_ovf  = clr;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NBTN; i++) hold[i] = 0;
        for (int j = 0; j < NB; j++) mpend[j] = 1'b0;
        movf   = 1'b0;
        mvalid = 1'b0;
        mptr   = 0;
        mgidx  = 0;
        mdata  = 8'h00;
    endtask

    task automatic model_step();
        bit ev [NB];
        int g;
        int j;
        bit lost;
        for (int i = 0; i < NBTN; i++) begin
            if (btn[i]) hold[i]++;
            else hold[i] = 0;
            ev[i]        = (hold[i] == 1);
            ev[NBTN + i] = (hold[i] == LONG);
        end
        g = -1;
        if (!mvalid) begin
            for (int k = 0; k < NB; k++) begin
                j = (mptr + k) % NB;
                if (g < 0 && mpend[j]) g = j;
            end
        end else if (tx_ready) begin
            mvalid = 1'b0;
            mptr   = (mgidx + 1) % NB;
        end
        lost = 1'b0;
        for (int n = 0; n < NB; n++) begin
            if (ev[n] && mpend[n] && n != g) lost = 1'b1;
            mpend[n] = (mpend[n] && n != g) || ev[n];
        end
        if (lost) movf = 1'b1;
        else if (clr_ovf) movf = 1'b0;
        if (g >= 0) begin
            mvalid = 1'b1;
            mgidx  = g;
            mdata  = (g < NBTN) ? 8'(32'h41 + g) : 8'(32'h61 + g - NBTN);
        end
    endtask

    function automatic logic [NB-1:0] model_pending();
        logic [NB-1:0] p;
        for (int j = 0; j < NB; j++) p[j] = mpend[j];
        return p;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (n_rst) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        checkOutput("cmp_tx_valid", tx_valid, mvalid);
        if (mvalid) checkOutput("cmp_tx_data", tx_data, mdata);
        checkOutput("cmp_pending", pending, model_pending());
        checkOutput("cmp_ovf", ovf, movf);
    end

    initial begin
        logic exp_v;
        model_reset();
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_ovf", ovf, 0);
        n_rst = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        repeat (2) cycle();

        $display("[TB] single press");
        applyStimulus(4'b0100, 1'b1, 1'b0);
        cycle();
        checkOutput("press_pending", pending, 8'h04);
        cycle();
        checkOutput("press_valid", tx_valid, 1);
        checkOutput("press_data", tx_data, 8'h43);
        checkOutput("press_pending_clr", pending, 0);
        cycle();
        checkOutput("press_valid_drop", tx_valid, 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        repeat (2) cycle();

        $display("[TB] long press");
        applyStimulus(4'b0010, 1'b1, 1'b0);
        cycle();
        for (int k = 1; k <= 20; k++) begin
            cycle();
            exp_v = (k == 1 || k == 10);
            checkOutput($sformatf("long_valid_k%0d", k), tx_valid, exp_v);
            if (exp_v) checkOutput($sformatf("long_data_k%0d", k), tx_data, (k == 1) ? 8'h42 : 8'h62);
        end
        applyStimulus(4'b0000, 1'b1, 1'b0);
        repeat (3) cycle();
        checkOutput("long_quiet", tx_valid, 0);

        $display("[TB] round robin");
        for (int r = 0; r < 2; r++) begin
            applyStimulus(4'b1001, 1'b1, 1'b0);
            cycle();
            for (int k = 1; k <= 4; k++) begin
                cycle();
                checkOutput($sformatf("rr%0d_valid_k%0d", r, k), tx_valid, (k % 2));
                if (k == 1) checkOutput($sformatf("rr%0d_first", r), tx_data, 8'h41);
                if (k == 3) checkOutput($sformatf("rr%0d_second", r), tx_data, 8'h44);
            end
            applyStimulus(4'b0000, 1'b1, 1'b0);
            cycle();
        end

        $display("[TB] backpressure");
        applyStimulus(4'b0001, 1'b0, 1'b0);
        cycle();
        cycle();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            checkOutput($sformatf("bp_valid_%0d", k), tx_valid, 1);
            checkOutput($sformatf("bp_data_%0d", k), tx_data, 8'h41);
            cycle();
        end
        applyStimulus(4'b0000, 1'b1, 1'b0);
        cycle();
        checkOutput("bp_handshake", tx_valid, 0);

        $display("[TB] overflow");
        applyStimulus(4'b0001, 1'b0, 1'b0);
        cycle();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        cycle();
        checkOutput("ovf_sending", tx_valid, 1);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        cycle();
        checkOutput("ovf_repend", pending, 8'h01);
        checkOutput("ovf_not_yet", ovf, 0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        cycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        cycle();
        checkOutput("ovf_set", ovf, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            checkOutput($sformatf("ovf_sticky_%0d", k), ovf, 1);
        end
        applyStimulus(4'b0000, 1'b0, 1'b1);
        cycle();
        checkOutput("ovf_cleared", ovf, 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        repeat (4) cycle();
        checkOutput("ovf_drained", tx_valid, 0);
        checkOutput("ovf_drained_pend", pending, 0);

        $display("[TB] reset mid-send");
        applyStimulus(4'b0110, 1'b0, 1'b0);
        cycle();
        cycle();
        checkOutput("rs_sending", tx_valid, 1);
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        checkOutput("rs_valid_async", tx_valid, 0);
        checkOutput("rs_pending_async", pending, 0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        repeat (2) cycle();
        n_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checkOutput($sformatf("rs_no_resend_%0d", k), tx_valid, 0);
        end
        #1;
        n_rst = 1'b0;
        model_reset();
        applyStimulus(4'b1000, 1'b0, 1'b0);
        cycle();
        n_rst = 1'b1;
        cycle();
        checkOutput("rs_held_pending", pending, 8'h08);
        cycle();
        checkOutput("rs_held_valid", tx_valid, 1);
        checkOutput("rs_held_data", tx_data, 8'h44);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        cycle();
        checkOutput("rs_held_done", tx_valid, 0);

        $display("[TB] random phase");
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NBTN; i++) begin
                if ($urandom_range(7) == 0) btn[i] = ~btn[i];
            end
            tx_ready = ($urandom_range(3) != 0);
            clr_ovf  = ($urandom_range(15) == 0);
            if ($urandom_range(399) == 0) begin
                #1;
                n_rst = 1'b0;
                model_reset();
                cycle();
                cycle();
                n_rst = 1'b1;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
